int8_nxn_matmul_stream: RTL and testbench
=========================================

// Module: int8_nxn_matmul_stream
// PURPOSE
// - Parametrised NxN int8 matrix multiply, C = A x B, with AXI-Stream operands and ap_ctrl_chain control.
// - Successor to the fixed 16x16 tensor-slice wrapper. Self-contained MAC array, no black boxes.
// - Adds full B buffering, per-row compute overlapped with C backpressure, and correct tvalid/tready handshakes.
// - Sits behind the HLS c-api library as a callable blackbox kernel.
// PARAMETERS
// - N       16  matrix dimension; 2..32.
// - ACC_W   32  accumulator/output element width; must be >= 16+$clog2(N) (elaboration $error otherwise).
// - SIGNED  1   1: operands are two's-complement int8. 0: operands are uint8.
// PORTS
// - ap_clk       in   1        single clock; all logic is rising-edge.
// - ap_rst       in   1        asynchronous, active-high reset.
// - ap_ce        in   1        clock enable; when low, all state is frozen and a/b_tready read 0.
// - ap_start     in   1        start request; sampled only in IDLE.
// - ap_done      out  1        high in DONE until ap_continue.
// - ap_idle      out  1        high in IDLE.
// - ap_ready     out  1        1-cycle pulse when the last A row is accepted.
// - ap_continue  in   1        acknowledges done; DONE -> IDLE.
// - a_tdata      in   N*8      row i of A; A[i][k] at [k*8 +: 8].
// - a_tvalid / a_tready  in/out  1  handshake for the A stream.
// - b_tdata      in   N*8      column j of B; B[k][j] at [k*8 +: 8].
// - b_tvalid / b_tready  in/out  1  handshake for the B stream.
// - c_tdata      out  N*ACC_W  row i of C; C[i][j] at [j*ACC_W +: ACC_W].
// - c_tvalid / c_tready  out/in  1  handshake for the C stream.
// BEHAVIOUR
// - Reset: state=IDLE, counters 0, c_tvalid=0, c_tdata=0, ap_done=0, ap_ready=0, accumulators 0.
// - Reset mid-run discards all buffered and in-flight data.
// - A transfer occurs only on tvalid&&tready&&ap_ce. Once asserted, c_tvalid/c_tdata stay stable until accepted.
// - FSM states:
//   - IDLE: ap_start -> LOAD_B. Clears the row counter. ap_start in any other state is ignored.
//   - LOAD_B: b_tready=1. Each accepted column j goes into the B buffer. The Nth column -> WAIT_A.
//   - WAIT_A: a_tready=1. The accepted row is latched, accumulators are cleared, k=0 -> MAC.
//   - MAC: one k per cycle: acc[j] += A[i][k]*B[k][j] for all j in parallel. After k=N-1 -> WB.
//     - Products are sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_W.
//     - Sums wrap modulo 2^ACC_W; the ACC_W rule guarantees no wrap for legal inputs.
//   - WB: if !c_tvalid || c_tready, load c_tdata, set c_tvalid=1, and go to WAIT_A (row<N-1) or DRAIN (row==N-1).
//     Otherwise hold WB (stall; accumulators keep their value).
//   - DRAIN: wait for the last C handshake, then c_tvalid=0 -> DONE.
//   - DONE: ap_done=1. ap_continue -> IDLE.
// - Outside DRAIN, c_tvalid clears on c_tready unless WB reloads it in the same cycle.
// - Overlap: row i+1 is accepted and MACed while row i waits in the C register.
// - Per-row latency: A handshake to c_tvalid = N+1 cycles with no stall.
// - Throughput: N+2 cycles per row.
// - a_tvalid during LOAD_B is not accepted (a_tready=0). Streams are strictly B-then-A.
// - Simultaneous c_tready and WB reload: the old row is accepted and the new row is loaded in the same edge, with no bubble.
// CONFIGURATION
// - Macro INT8_MATMUL_RELU_EN.
//   - Defined: at WB, each element < 0 is written as 0 (SIGNED=1 only; no effect when SIGNED=0).
//   - Undefined: raw accumulator values are output.
//   - Timing and handshakes are identical in both builds.
// STRUCTURE
// - Package int8_mm_pkg holds:
//   - state enum (IDLE, LOAD_B, WAIT_A, MAC, WB, DRAIN, DONE);
//   - helper function acc_min_w(n) = 16+$clog2(n);
//   - localparam BYTE_W=8.
// - Sub-module int8_mac_lane (ACC_W, SIGNED), generated N times: clear, en, a, b -> acc.
// - The top-level holds the FSM, counters, the B buffer (N*N bytes as registers) and the C output register.
// TESTING
// - Identity: N=16, B=I, A[i][k]=i+k -> C row i equals A row i zero/sign-extended; 16 rows, ap_done after row 15.
// - Extremes: SIGNED=1, A=B=all -128 -> every C element = 262144 (0x40000).
//   The same run with SIGNED=0 and all 0xFF -> 1040400.
// - Backpressure: c_tready=0 for 50 cycles after row 0 ->
//   - c_tdata stable throughout;
//   - row 1 computed and held in WB;
//   - a_tready=0 until released;
//   - no rows lost or duplicated.
// - ap_ce low 10 cycles mid-MAC: the result equals the ap_ce=1 golden result, and no handshake occurs while ap_ce=0.
// - Async reset mid-MAC: outputs are 0 immediately. A full re-run afterwards matches golden. ap_start during DONE is ignored.
// - INT8_MATMUL_RELU_EN defined, A=I, B=-I -> all C elements 0. Undefined -> the diagonal is -1.

Source files
------------

// File: rtl/int8_mm_pkg.sv
// Shared types and helpers for the NxN int8 matrix-multiply stream kernel.
package int8_mm_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_B,
    WAIT_A,
    MAC,
    WB,
    DRAIN,
    DONE
  } mm_state_e;

  // Narrowest accumulator that cannot overflow for N products of int8/uint8.
  function automatic int acc_min_w(input int n);
    return 16 + $clog2(n);
  endfunction
endpackage

// File: rtl/int8_mac_lane.sv
// One output column of the MAC array: acc += a*b with sign/zero extension to ACC_W.
module int8_mac_lane
  import int8_mm_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int SIGNED = 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o
);
  logic [ACC_W-1:0] a_x, b_x, prod, acc_q;

  // Low ACC_W bits of the extended product are the same for signed and unsigned multiply.
  if (SIGNED != 0) begin : g_sx
    assign a_x = {{(ACC_W-BYTE_W){a_i[BYTE_W-1]}}, a_i};
    assign b_x = {{(ACC_W-BYTE_W){b_i[BYTE_W-1]}}, b_i};
  end else begin : g_zx
    assign a_x = {{(ACC_W-BYTE_W){1'b0}}, a_i};
    assign b_x = {{(ACC_W-BYTE_W){1'b0}}, b_i};
  end

  assign prod = a_x * b_x;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)       acc_q <= '0;
    else if (clear_i) acc_q <= '0;
    else if (en_i)    acc_q <= acc_q + prod;
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/int8_nxn_matmul_stream.sv
// NxN int8 matmul C = A x B over AXI-Stream with ap_ctrl_chain control.
// Build option INT8_MATMUL_RELU_EN clamps negative C elements to zero (SIGNED=1 only).
module int8_nxn_matmul_stream
  import int8_mm_pkg::*;
#(
  parameter int N      = 16,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 1
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_ce,
  input  logic                 ap_start,
  output logic                 ap_done,
  output logic                 ap_idle,
  output logic                 ap_ready,
  input  logic                 ap_continue,
  input  logic [N*BYTE_W-1:0]  a_tdata,
  input  logic                 a_tvalid,
  output logic                 a_tready,
  input  logic [N*BYTE_W-1:0]  b_tdata,
  input  logic                 b_tvalid,
  output logic                 b_tready,
  output logic [N*ACC_W-1:0]   c_tdata,
  output logic                 c_tvalid,
  input  logic                 c_tready
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N-1);

  if (ACC_W < acc_min_w(N)) begin : g_bad_acc_w
    $error("ACC_W too narrow for N");
  end

  mm_state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d, k_q, k_d;
  logic          c_tvalid_q, c_tvalid_d;
  logic [N-1:0][BYTE_W-1:0]         a_row_q;
  logic [N-1:0][N-1:0][BYTE_W-1:0]  b_buf_q;   // [column j][k]
  logic [N-1:0][ACC_W-1:0]          acc, c_res, c_tdata_q;
  logic a_hs, b_hs, c_hs, wb_load, mac_en;

  assign a_tready = ap_ce && (state_q == WAIT_A);
  assign b_tready = ap_ce && (state_q == LOAD_B);
  assign a_hs     = a_tvalid && a_tready;
  assign b_hs     = b_tvalid && b_tready;
  assign c_hs     = c_tvalid_q && c_tready && ap_ce;
  assign wb_load  = ap_ce && (state_q == WB) && (!c_tvalid_q || c_tready);
  assign mac_en   = ap_ce && (state_q == MAC);

  assign ap_idle  = (state_q == IDLE);
  assign ap_done  = (state_q == DONE);
  assign ap_ready = a_hs && (row_q == LAST);
  assign c_tvalid = c_tvalid_q;
  assign c_tdata  = c_tdata_q;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    k_d        = k_q;
    c_tvalid_d = c_hs ? 1'b0 : c_tvalid_q;
    case (state_q)
      IDLE:   if (ap_start) begin
                state_d = LOAD_B;
                row_d   = '0;
                col_d   = '0;
              end
      LOAD_B: if (b_hs) begin
                col_d = col_q + CW'(1);
                if (col_q == LAST) begin
                  col_d   = '0;
                  state_d = WAIT_A;
                end
              end
      WAIT_A: if (a_hs) begin
                k_d     = '0;
                state_d = MAC;
              end
      MAC:    begin
                k_d = k_q + CW'(1);
                if (k_q == LAST) begin
                  k_d     = '0;
                  state_d = WB;
                end
              end
      WB:     if (wb_load) begin
                c_tvalid_d = 1'b1;
                row_d      = row_q + CW'(1);
                state_d    = (row_q == LAST) ? DRAIN : WAIT_A;
              end
      DRAIN:  if (c_hs) state_d = DONE;
      DONE:   if (ap_continue) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      k_q        <= '0;
      c_tvalid_q <= 1'b0;
    end else if (ap_ce) begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      k_q        <= k_d;
      c_tvalid_q <= c_tvalid_d;
    end
  end

  // Handshake strobes already carry ap_ce, so these enables freeze with it.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      a_row_q   <= '0;
      b_buf_q   <= '0;
      c_tdata_q <= '0;
    end else begin
      if (b_hs)    b_buf_q[col_q] <= b_tdata;
      if (a_hs)    a_row_q        <= a_tdata;
      if (wb_load) c_tdata_q      <= c_res;
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_lane
    int8_mac_lane #(.ACC_W(ACC_W), .SIGNED(SIGNED)) u_lane (
      .ap_clk  (ap_clk),
      .ap_rst  (ap_rst),
      .clear_i (a_hs),
      .en_i    (mac_en),
      .a_i     (a_row_q[k_q]),
      .b_i     (b_buf_q[j][k_q]),
      .acc_o   (acc[j])
    );
`ifdef INT8_MATMUL_RELU_EN
    assign c_res[j] = ((SIGNED != 0) && acc[j][ACC_W-1]) ? '0 : acc[j];
`else
    assign c_res[j] = acc[j];
`endif
  end
endmodule

// File: tb/tb_int8_nxn_matmul_stream.sv
// Directed bench: signed and unsigned instances driven in lockstep with shared stimulus.
module tb_int8_nxn_matmul_stream;
  localparam int N  = 16;
  localparam int AW = 32;
  localparam int TO = 600;

  logic ap_clk = 1'b0, ap_rst = 1'b1, ap_ce = 1'b1, ap_start = 1'b0, ap_continue = 1'b0;
  logic [N*8-1:0] a_tdata = '0, b_tdata = '0;
  logic a_tvalid = 1'b0, b_tvalid = 1'b0, c_tready = 1'b0;

  logic ap_done_s, ap_idle_s, ap_ready_s, a_tready_s, b_tready_s, c_tvalid_s;
  logic ap_done_u, ap_idle_u, ap_ready_u, a_tready_u, b_tready_u, c_tvalid_u;
  logic [N*AW-1:0] c_tdata_s, c_tdata_u;

  int8_nxn_matmul_stream #(.N(N), .ACC_W(AW), .SIGNED(1)) dut_s (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce), .ap_start(ap_start),
    .ap_done(ap_done_s), .ap_idle(ap_idle_s), .ap_ready(ap_ready_s), .ap_continue(ap_continue),
    .a_tdata(a_tdata), .a_tvalid(a_tvalid), .a_tready(a_tready_s),
    .b_tdata(b_tdata), .b_tvalid(b_tvalid), .b_tready(b_tready_s),
    .c_tdata(c_tdata_s), .c_tvalid(c_tvalid_s), .c_tready(c_tready));

  int8_nxn_matmul_stream #(.N(N), .ACC_W(AW), .SIGNED(0)) dut_u (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce), .ap_start(ap_start),
    .ap_done(ap_done_u), .ap_idle(ap_idle_u), .ap_ready(ap_ready_u), .ap_continue(ap_continue),
    .a_tdata(a_tdata), .a_tvalid(a_tvalid), .a_tready(a_tready_u),
    .b_tdata(b_tdata), .b_tvalid(b_tvalid), .b_tready(b_tready_u),
    .c_tdata(c_tdata_u), .c_tvalid(c_tvalid_u), .c_tready(c_tready));

  always #5 ap_clk = ~ap_clk;

  typedef struct { logic [7:0] a; logic [7:0] b; int es; int eu; } vec_t;
  vec_t tbl [6];

  int errors = 0, checks = 0, ready_cnt = 0;
  logic [7:0] A [N][N];
  logic [7:0] B [N][N];
  logic [N*AW-1:0] EXs [N];
  logic [N*AW-1:0] EXu [N];

  always @(negedge ap_clk) begin
    #3;
    if (ap_ready_s) ready_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge ap_clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [N*AW-1:0] act, input logic [N*AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int relu(input int v);
`ifdef INT8_MATMUL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [N*8-1:0] rowbits(input int i);
    logic [N*8-1:0] r;
    for (int k = 0; k < N; k++) r[k*8 +: 8] = A[i][k];
    return r;
  endfunction

  function automatic logic [N*8-1:0] colbits(input int j);
    logic [N*8-1:0] r;
    for (int k = 0; k < N; k++) r[k*8 +: 8] = B[k][j];
    return r;
  endfunction

  task automatic set_uniform(input logic [7:0] a, input logic [7:0] b, input int es, input int eu);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = a;
        B[i][j] = b;
        EXs[i][j*AW +: AW] = relu(es);
        EXu[i][j*AW +: AW] = eu;
      end
  endtask

  // A[i][k] = i+k, B = I  ->  C[i][j] = i+j
  task automatic set_identity();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = 8'(i + j);
        B[i][j] = (i == j) ? 8'd1 : 8'd0;
        EXs[i][j*AW +: AW] = i + j;
        EXu[i][j*AW +: AW] = i + j;
      end
  endtask

  // A = I, B = -I  ->  diagonal -1 signed (0 with ReLU), 255 unsigned
  task automatic set_negi();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = (i == j) ? 8'd1 : 8'd0;
        B[i][j] = (i == j) ? 8'hFF : 8'd0;
        EXs[i][j*AW +: AW] = (i == j) ? relu(-1) : 0;
        EXu[i][j*AW +: AW] = (i == j) ? 255 : 0;
      end
  endtask

  task automatic start_k();
    check("idle_before_start", ap_idle_s, 1);
    ready_cnt = 0;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
  endtask

  task automatic send_b();
    int t;
    for (int j = 0; j < N; j++) begin
      b_tdata = colbits(j);
      b_tvalid = 1'b1;
      #1;
      t = 0;
      while (!b_tready_s && t < TO) begin step(); #1; t++; end
      check("b_hs_in_time", t < TO, 1);
      step();
    end
    b_tvalid = 1'b0;
  endtask

  task automatic ce_pause();
    logic [N*AW-1:0] snap;
    logic snap_v, quiet;
    repeat (3) step();
    ap_ce = 1'b0;
    snap = c_tdata_s;
    snap_v = c_tvalid_s;
    quiet = 1'b1;
    repeat (10) begin
      #1;
      if (a_tready_s || b_tready_s || a_tready_u || c_tvalid_s !== snap_v || c_tdata_s !== snap)
        quiet = 1'b0;
      step();
    end
    check("ce_low_frozen", quiet, 1);
    ap_ce = 1'b1;
  endtask

  task automatic send_a(input bit cep);
    int t;
    for (int i = 0; i < N; i++) begin
      a_tdata = rowbits(i);
      a_tvalid = 1'b1;
      #1;
      t = 0;
      while (!a_tready_s && t < TO) begin step(); #1; t++; end
      check("a_hs_in_time", t < TO, 1);
      step();
      if (cep && i == 2) begin
        a_tvalid = 1'b0;
        ce_pause();
      end
    end
    a_tvalid = 1'b0;
  endtask

  task automatic collect(input bit bp);
    int t;
    logic [N*AW-1:0] snap;
    logic stable;
    if (bp) begin
      c_tready = 1'b0;
      #1;
      t = 0;
      while (!c_tvalid_s && t < TO) begin step(); #1; t++; end
      check("bp_row0_valid", c_tvalid_s, 1);
      snap = c_tdata_s;
      stable = 1'b1;
      repeat (50) begin
        step(); #1;
        if (c_tdata_s !== snap || !c_tvalid_s) stable = 1'b0;
      end
      check("bp_cdata_stable", stable, 1);
      check("bp_row0_value", snap, EXs[0]);
      check("bp_a_tready_low", a_tready_s, 0);
    end
    c_tready = 1'b1;
    for (int r = 0; r < N; r++) begin
      #1;
      t = 0;
      while (!(c_tvalid_s && ap_ce) && t < TO) begin step(); #1; t++; end
      check($sformatf("row%0d_valid", r), c_tvalid_s && c_tvalid_u, 1);
      check($sformatf("row%0d_s", r), c_tdata_s, EXs[r]);
      check($sformatf("row%0d_u", r), c_tdata_u, EXu[r]);
      step();
    end
    #1;
    check("done_after_last_row", {ap_done_s, ap_done_u}, 2'b11);
  endtask

  task automatic end_k();
    step();
    ap_start = 1'b1;
    repeat (3) step();
    ap_start = 1'b0;
    #1;
    check("start_in_done_ignored", {ap_done_s, b_tready_s}, 2'b10);
    check("ap_ready_pulses", ready_cnt, 1);
    step();
    ap_continue = 1'b1;
    step();
    ap_continue = 1'b0;
    #1;
    check("idle_after_continue", {ap_idle_s, ap_done_s}, 2'b10);
    step();
  endtask

  task automatic run(input bit bp, input bit cep);
    start_k();
    fork
      begin send_b(); send_a(cep); end
      collect(bp);
    join
    end_k();
  endtask

  task automatic rst_mid();
    int t;
    set_identity();
    start_k();
    send_b();
    c_tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_tdata = rowbits(i);
      a_tvalid = 1'b1;
      #1;
      t = 0;
      while (!a_tready_s && t < TO) begin step(); #1; t++; end
      check("rst_a_hs_in_time", t < TO, 1);
      step();
    end
    a_tvalid = 1'b0;
    repeat (4) step();
    check("rst_pre_cvalid", c_tvalid_s, 1);
    #2;
    ap_rst = 1'b1;
    #1;
    check("rst_async_cvalid", {c_tvalid_s, c_tvalid_u}, 2'b00);
    check("rst_async_cdata_s", c_tdata_s, '0);
    check("rst_async_cdata_u", c_tdata_u, '0);
    check("rst_async_ctrl", {ap_idle_s, ap_done_s, a_tready_s}, 3'b100);
    step();
    ap_rst = 1'b0;
    c_tready = 1'b1;
    step();
  endtask

  initial begin
    tbl[0] = '{8'h80, 8'h80, 262144, 262144};
    tbl[1] = '{8'hFF, 8'hFF, 16, 1040400};
    tbl[2] = '{8'h01, 8'hFF, -16, 4080};
    tbl[3] = '{8'h7F, 8'h80, -260096, 260096};
    tbl[4] = '{8'h00, 8'h55, 0, 0};
    tbl[5] = '{8'h03, 8'h05, 240, 240};

    step(); step();
    check("reset_ctrl", {ap_idle_s, ap_done_s, ap_ready_s, a_tready_s, b_tready_s}, 5'b10000);
    check("reset_cvalid", {c_tvalid_s, c_tvalid_u}, 2'b00);
    check("reset_cdata", c_tdata_s, '0);
    ap_rst = 1'b0;
    step();

    set_identity();
    run(0, 0);
    for (int v = 0; v < 6; v++) begin
      set_uniform(tbl[v].a, tbl[v].b, tbl[v].es, tbl[v].eu);
      run(0, 0);
    end
    set_identity();
    run(1, 0);
    run(0, 1);
    set_negi();
    run(0, 0);
    rst_mid();
    set_identity();
    run(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
